wb_master_arbiter: RTL
======================

// Module: wb_master_arbiter
//
// PURPOSE
// - Two-master round-robin arbiter for the classic Wishbone bus; sits between the masters and wb_interconnect.
// - Masters are M0 (CPU) and M1 (debug/DMA). The single downstream port drives the interconnect master port.
// - A grant is held for a whole CYC_O block. A bus-timeout watchdog aborts stalled cycles with ERR.
//
// PARAMETERS
// - ADDR_WIDTH      32   address width, all ports
// - DATA_WIDTH      32   data width; SEL width = DATA_WIDTH/8
// - TIMEOUT_CYCLES  255  cycles without S_ACK_O before abort; 0 disables the watchdog
//
// PORTS
// - clk_i            in   1       single clock, rising edge
// - rst_i            in   1       synchronous, active-high reset
// - Mn_ADR_O         in   ADDR    master n address; n = 0,1 for every Mn_ line
// - Mn_DAT_O         in   DATA    master n write data
// - Mn_WE_O          in   1       master n write enable
// - Mn_SEL_O         in   DATA/8  master n byte selects
// - Mn_STB_O         in   1       master n strobe
// - Mn_CYC_O         in   1       master n cycle (request)
// - Mn_DAT_I         out  DATA    read data to master n
// - Mn_ACK_I         out  1       acknowledge to master n
// - Mn_ERR_I         out  1       timeout error to master n
// - S_DAT_I          out  DATA    write data downstream
// - S_ADR_I          out  ADDR    address downstream
// - S_WE_I           out  1       write enable downstream
// - S_SEL_I          out  DATA/8  byte selects downstream
// - S_STB_I          out  1       strobe downstream
// - S_CYC_I          out  1       cycle downstream
// - S_DAT_O          in   DATA    read data from downstream
// - S_ACK_O          in   1       acknowledge from downstream
// - grant_o          out  2       one-hot current owner; 00 = none
// - timeout_o        out  1       one-cycle pulse on watchdog abort
//
// BEHAVIOUR
// - Request: reqn = Mn_CYC_O & Mn_STB_O.
// - FSM states: IDLE, GNT0, GNT1, ABORT. State is registered; every output is a combinational function of state.
// - Reset: state = IDLE, last_owner = 1 (so M0 wins the first tie), timer = 0.
//   All outputs are 0 while in IDLE; this holds in the cycle after rst_i regardless of the prior state.
// - IDLE:
//   - only req0 -> GNT0; only req1 -> GNT1.
//   - both -> the master != last_owner.
//   - Arbitration latency is 1 cycle: no S_* activity in the request cycle.
// - GNTn:
//   - All S_* outputs equal Mn_* (CYC, STB, WE, SEL, ADR, DAT).
//   - Mn_DAT_I = S_DAT_O and Mn_ACK_I = S_ACK_O; the other master sees DAT/ACK/ERR = 0.
//   - grant_o = one-hot n.
//   - On entry, last_owner <= n.
// - GNTn exit: Mn_CYC_O = 0 -> IDLE next cycle. One idle cycle is guaranteed between owners (no back-to-back handover).
//   - The other master's request is ignored for the whole block, even if the owner drops STB between beats.
// - Watchdog timer:
//   - Clears to 0 on S_ACK_O, on state entry, and whenever the owner's STB = 0.
//   - Otherwise increments in GNTn, saturating at TIMEOUT_CYCLES.
//   - Timer = TIMEOUT_CYCLES with STB = 1 and no ACK -> ABORT.
//   - Width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
// - ABORT (exactly 1 cycle):
//   - S_CYC_I = S_STB_I = 0.
//   - Owner's Mn_ERR_I = 1 and timeout_o = 1; grant_o still shows the owner.
//   - Then -> IDLE. If the master still requests, it re-arbitrates normally.
// - S_ACK_O arriving in the same cycle the timer hits its limit: ACK wins, the timer clears, no abort.
// - A stray S_ACK_O in IDLE/ABORT is dropped and never forwarded.
// - TIMEOUT_CYCLES = 0: ABORT is unreachable and timeout_o stays 0.
//
// STRUCTURE
// - wb_pkg: arb_state_t enum {IDLE, GNT0, GNT1, ABORT} and GRANT_M0/GRANT_M1 one-hot constants, shared with wb_interconnect.
// - Sub-module wb_bus_watchdog: parameterised saturating timer (clear, enable, expired outputs).
// - Muxing and the FSM stay in this module.
//
// TESTING
// - Reset release, then M0 read with ACK in cycle 3 -> S_CYC_I rises 1 cycle after request; M0_DAT_I = S_DAT_O; grant_o = 01.
// - M0 and M1 request in the same cycle, repeatedly -> grants alternate M0, M1, M0 with one IDLE cycle between.
// - M0 holds CYC for a 4-beat block while M1 requests -> M1 is granted only after M0 drops CYC; M1_ACK_I = 0 throughout.
// - TIMEOUT_CYCLES = 4, no ACK -> ABORT after 4 cycles; M0_ERR_I and timeout_o pulse for 1 cycle; S_CYC_I = 0 in that cycle.
// - ACK arrives in the same cycle as timer expiry -> normal ACK, no ERR.
// - rst_i asserted mid-GNT1 -> next cycle all outputs 0; the next tie goes to M0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone arbitration types: FSM state encoding and one-hot grant codes.
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT0  = 2'd1,
      GNT1  = 2'd2,
      ABORT = 2'd3
   } arb_state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   // One-hot grant code for a single-bit owner index.
   function automatic logic [1:0] grant_of(input logic owner);
      return owner ? GRANT_M1 : GRANT_M0;
   endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Saturating bus-stall timer. Counts enabled cycles since the last clear and
// flags expiry once the count reaches LIMIT. LIMIT = 0 disables expiry.
module wb_bus_watchdog #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic srst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [TW-1:0] LIMIT_V = TW'(LIMIT);

   logic [TW-1:0] timer_reg;
   logic [TW-1:0] timer_next;

   // Clear has priority; otherwise count up and hold at the limit.
   always_comb begin
      timer_next = timer_reg;
      if (clear) begin
         timer_next = '0;
      end else if (enable && (timer_reg != LIMIT_V)) begin
         timer_next = timer_reg + 1'b1;
      end
   end

   // Timer register.
   always_ff @(posedge clk) begin
      if (srst) begin
         timer_reg <= '0;
      end else begin
         timer_reg <= timer_next;
      end
   end

   generate
      if (LIMIT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         assign expired = (timer_reg == LIMIT_V);
      end
   endgenerate

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter. A grant lasts for a whole CYC
// block; a watchdog aborts a stalled owner with a one-cycle ERR.
module wb_master_arbiter
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDR_WIDTH-1:0]   M0_ADR_O,
   input  logic [DATA_WIDTH-1:0]   M0_DAT_O,
   input  logic                    M0_WE_O,
   input  logic [DATA_WIDTH/8-1:0] M0_SEL_O,
   input  logic                    M0_STB_O,
   input  logic                    M0_CYC_O,
   output logic [DATA_WIDTH-1:0]   M0_DAT_I,
   output logic                    M0_ACK_I,
   output logic                    M0_ERR_I,
   input  logic [ADDR_WIDTH-1:0]   M1_ADR_O,
   input  logic [DATA_WIDTH-1:0]   M1_DAT_O,
   input  logic                    M1_WE_O,
   input  logic [DATA_WIDTH/8-1:0] M1_SEL_O,
   input  logic                    M1_STB_O,
   input  logic                    M1_CYC_O,
   output logic [DATA_WIDTH-1:0]   M1_DAT_I,
   output logic                    M1_ACK_I,
   output logic                    M1_ERR_I,
   output logic [DATA_WIDTH-1:0]   S_DAT_I,
   output logic [ADDR_WIDTH-1:0]   S_ADR_I,
   output logic                    S_WE_I,
   output logic [DATA_WIDTH/8-1:0] S_SEL_I,
   output logic                    S_STB_I,
   output logic                    S_CYC_I,
   input  logic [DATA_WIDTH-1:0]   S_DAT_O,
   input  logic                    S_ACK_O,
   output logic [1:0]              grant_o,
   output logic                    timeout_o
);

   localparam int SEL_W = DATA_WIDTH / 8;

   // Master-side signals gathered into arrays so the owner can index them.
   logic [ADDR_WIDTH-1:0] m_adr [2];
   logic [DATA_WIDTH-1:0] m_dat [2];
   logic [SEL_W-1:0]      m_sel [2];
   logic                  m_we  [2];
   logic                  m_stb [2];
   logic                  m_cyc [2];
   logic [DATA_WIDTH-1:0] m_rdat [2];
   logic                  m_ack [2];
   logic                  m_err [2];
   logic [1:0]            req;

   assign m_adr[0] = M0_ADR_O;
   assign m_adr[1] = M1_ADR_O;
   assign m_dat[0] = M0_DAT_O;
   assign m_dat[1] = M1_DAT_O;
   assign m_sel[0] = M0_SEL_O;
   assign m_sel[1] = M1_SEL_O;
   assign m_we[0]  = M0_WE_O;
   assign m_we[1]  = M1_WE_O;
   assign m_stb[0] = M0_STB_O;
   assign m_stb[1] = M1_STB_O;
   assign m_cyc[0] = M0_CYC_O;
   assign m_cyc[1] = M1_CYC_O;

   arb_state_t state_reg, state_next;
   logic       last_owner_reg, last_owner_next;
   logic       owner;
   logic       in_gnt;
   logic       wd_clear;
   logic       wd_expired;

   // In ABORT the owner is the master granted on the last entry.
   assign in_gnt = (state_reg == GNT0) || (state_reg == GNT1);
   assign owner  = (state_reg == GNT1) ? 1'b1 :
                   (state_reg == GNT0) ? 1'b0 : last_owner_reg;

   // Timer runs only while the owner strobes without being acknowledged.
   assign wd_clear = !in_gnt || !m_stb[owner] || S_ACK_O;

   wb_bus_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk_i),
      .srst    (rst_i),
      .clear   (wd_clear),
      .enable  (in_gnt),
      .expired (wd_expired)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master
         assign req[gi]    = m_cyc[gi] & m_stb[gi];
         // Return path only reaches the current owner; stray ACKs are dropped.
         assign m_ack[gi]  = in_gnt && (owner == 1'(gi)) && S_ACK_O;
         assign m_rdat[gi] = (in_gnt && (owner == 1'(gi))) ? S_DAT_O : '0;
         assign m_err[gi]  = (state_reg == ABORT) && (owner == 1'(gi));
      end
   endgenerate

   assign M0_DAT_I = m_rdat[0];
   assign M1_DAT_I = m_rdat[1];
   assign M0_ACK_I = m_ack[0];
   assign M1_ACK_I = m_ack[1];
   assign M0_ERR_I = m_err[0];
   assign M1_ERR_I = m_err[1];

   // State and round-robin history registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         last_owner_reg <= 1'b1;
      end else begin
         state_reg      <= state_next;
         last_owner_reg <= last_owner_next;
      end
   end

   // Next-state: arbitrate in IDLE, hold the grant until the owner drops CYC.
   always_comb begin
      state_next      = state_reg;
      last_owner_next = last_owner_reg;
      case (state_reg)
         IDLE: begin
            if (req[0] && (!req[1] || last_owner_reg)) begin
               state_next      = GNT0;
               last_owner_next = 1'b0;
            end else if (req[1]) begin
               state_next      = GNT1;
               last_owner_next = 1'b1;
            end
         end
         GNT0, GNT1: begin
            if (!m_cyc[owner]) begin
               state_next = IDLE;
            end else if (wd_expired && m_stb[owner] && !S_ACK_O) begin
               state_next = ABORT;
            end
         end
         ABORT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Downstream mux and status outputs, decoded from the registered state.
   always_comb begin
      S_CYC_I   = 1'b0;
      S_STB_I   = 1'b0;
      S_WE_I    = 1'b0;
      S_SEL_I   = '0;
      S_ADR_I   = '0;
      S_DAT_I   = '0;
      grant_o   = GRANT_NONE;
      timeout_o = 1'b0;
      if (in_gnt) begin
         S_CYC_I = m_cyc[owner];
         S_STB_I = m_stb[owner];
         S_WE_I  = m_we[owner];
         S_SEL_I = m_sel[owner];
         S_ADR_I = m_adr[owner];
         S_DAT_I = m_dat[owner];
         grant_o = grant_of(owner);
      end else if (state_reg == ABORT) begin
         grant_o   = grant_of(owner);
         timeout_o = 1'b1;
      end
   end

endmodule
